// File: rtl/word_buf_16.sv
// First-word-fall-through buffer of DEPTH 16-bit words with a sticky drop flag.
// Optional occupancy output `level` is enabled by defining WORD_BUF_LEVEL_EN.
module word_buf_16 #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [15:0]             data_in,
  input  logic                    ready_in,
  output logic                    valid_out,
  output logic [15:0]             data_out,
  output logic                    overflow,
  output logic                    full
`ifdef WORD_BUF_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign valid_out = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = valid_out & ready_in;
  assign push      = valid_in & (~full | pop);

  // Gated so the head reads zero while empty, including straight out of reset.
  assign data_out  = valid_out ? mem[rd_ptr] : 16'h0000;

`ifdef WORD_BUF_LEVEL_EN
  assign level = count;
`endif

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Push and pop together leave occupancy unchanged, even when full.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (valid_in && !push) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_word_buf_16.sv
// Self-checking bench for word_buf_16: directed scenarios plus random traffic
// against a queue-based reference model; level checked when WORD_BUF_LEVEL_EN is set.
module tb_word_buf_16;

  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    valid_in;
  logic [15:0]             data_in;
  logic                    ready_in;
  logic                    valid_out;
  logic [15:0]             data_out;
  logic                    overflow;
  logic                    full;
`ifdef WORD_BUF_LEVEL_EN
  logic [$clog2(DEPTH):0]  level;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] q[$];
  bit          m_ovf;

  word_buf_16 #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .overflow  (overflow),
`ifdef WORD_BUF_LEVEL_EN
    .level     (level),
`endif
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid_out", {31'b0, valid_out}, {31'b0, q.size() != 0});
    chk("data_out", {16'b0, data_out}, (q.size() != 0) ? {16'b0, q[0]} : 32'h0);
    chk("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef WORD_BUF_LEVEL_EN
    chk("level", 32'(level), 32'(q.size()));
`endif
  endtask

  // Called at a negedge: drive inputs, cross one rising edge, update model, check at next negedge.
  task automatic step(input bit r, input bit v, input logic [15:0] d, input bit rdy);
    bit m_pop;
    bit m_push;
    rst      = r;
    valid_in = v;
    data_in  = d;
    ready_in = rdy;
    m_pop  = (q.size() != 0) && rdy;
    m_push = v && ((q.size() < DEPTH) || m_pop);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(d);
      if (v && !m_push) m_ovf = 1'b1;
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = 16'h0;
    ready_in = 1'b0;
    m_ovf    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("rst_valid", {31'b0, valid_out}, 32'h0);
    chk("rst_data", {16'b0, data_out}, 32'h0);
    chk("rst_full", {31'b0, full}, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);

    // Latency and hold
    step(1'b0, 1'b1, 16'hA1B2, 1'b0);
    chk("lat_valid", {31'b0, valid_out}, 32'h1);
    chk("lat_data", {16'b0, data_out}, 32'hA1B2);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("hold_data", {16'b0, data_out}, 32'hA1B2);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("lat_drained", {31'b0, valid_out}, 32'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("pop_empty", {31'b0, valid_out}, 32'h0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 16'(i), 1'b0);
`ifdef WORD_BUF_LEVEL_EN
      chk("fill_level", 32'(level), (i > 4) ? 32'd4 : 32'(i));
`endif
      if (i == 4) begin
        chk("fill_full4", {31'b0, full}, 32'h1);
        chk("fill_ovf4", {31'b0, overflow}, 32'h0);
      end
    end
    chk("fill_ovf5", {31'b0, overflow}, 32'h1);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", {16'b0, data_out}, 32'(i));
      step(1'b0, 1'b0, 16'h0, 1'b1);
    end
    chk("drain_empty", {31'b0, valid_out}, 32'h0);
    chk("ovf_sticky", {31'b0, overflow}, 32'h1);

    // Push while full with a simultaneous pop
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0010 + 16'(i), 1'b0);
    step(1'b0, 1'b1, 16'h00FF, 1'b1);
    chk("pof_ovf", {31'b0, overflow}, 32'h0);
    chk("pof_full", {31'b0, full}, 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("pof_last", {16'b0, data_out}, 32'h00FF);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("pof_empty", {31'b0, valid_out}, 32'h0);

    // Streaming through the pointer wrap
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b1);
      chk("stream_data", {16'b0, data_out}, 32'h0100 + 32'(i));
      chk("stream_full", {31'b0, full}, 32'h0);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("stream_empty", {31'b0, valid_out}, 32'h0);

    // Reset mid-operation with overflow set
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("pre_rst_ovf", {31'b0, overflow}, 32'h1);
    step(1'b1, 1'b1, 16'hDEAD, 1'b0);
    chk("mid_rst_valid", {31'b0, valid_out}, 32'h0);
    chk("mid_rst_data", {16'b0, data_out}, 32'h0);
    chk("mid_rst_ovf", {31'b0, overflow}, 32'h0);
    chk("mid_rst_full", {31'b0, full}, 32'h0);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("post_rst_push", {16'b0, data_out}, 32'hBEEF);

    // Random traffic with varying load
    for (int ph = 0; ph < 6; ph++) begin
      int pv;
      int pr;
      pv = 20 + 15 * ph;
      pr = 90 - 15 * ph;
      for (int n = 0; n < 400; n++) begin
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < pv,
             16'($urandom),
             $urandom_range(0, 99) < pr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/word_buf_16.md
WORD_BUF_16 -- requirements
Module: word_buf_16

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of 16-bit word entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port valid_in  input  1  upstream word strobe; no backpressure to upstream.
REQ-005 SHALL have port data_in  input  16  upstream word, sampled when valid_in=1.
REQ-006 SHALL have port ready_in  input  1  downstream accepts the head word this cycle.
REQ-007 SHALL have port valid_out  output  1  head word present.
REQ-008 SHALL have port data_out  output  16  head word.
REQ-009 SHALL have port overflow  output  1  sticky flag: a word was dropped.
REQ-010 SHALL have port full  output  1  occupancy equals DEPTH.

Function
REQ-011 SHALL operate as a first-word-fall-through FIFO of DEPTH entries; words leave in arrival order.
REQ-012 SHALL define push = valid_in AND (NOT full OR pop).
REQ-013 SHALL define pop = valid_out AND ready_in.
REQ-014 SHALL drive valid_out=1 exactly when occupancy is nonzero, with data_out equal to the oldest stored word.
REQ-015 SHALL make a word pushed at edge k visible on data_out/valid_out in the cycle after edge k when the FIFO was empty (1-cycle latency); no combinational path from data_in to data_out.
REQ-016 SHALL hold data_out stable while valid_out=1 and ready_in=0.
REQ-017 SHALL, on simultaneous push and pop, leave occupancy unchanged; this SHALL include the full case, where the incoming word is accepted.
REQ-018 SHALL, when valid_in=1, full=1 and pop=0, discard data_in, leave contents unchanged, and set overflow=1 at the next edge.
REQ-019 SHALL keep overflow at 1 until reset.
REQ-020 SHALL ignore ready_in when empty; pop on empty has no effect.
REQ-021 SHALL advance read and write pointers modulo DEPTH; wrap-around SHALL not disturb ordering.
REQ-022 SHALL keep occupancy in a counter of width log2(DEPTH)+1, ranging 0..DEPTH, never wrapping.

Reset
REQ-023 SHALL, when rst=1 at a rising edge, clear pointers and occupancy and force valid_out=0, data_out=16'h0000, overflow=0, full=0.
REQ-024 SHALL give rst priority over push and pop in the same cycle; in-flight words are lost and no push is recorded.
REQ-025 SHALL accept a push in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, when macro WORD_BUF_LEVEL_EN is defined, add output port level (width log2(DEPTH)+1) carrying current occupancy, reset to 0.
REQ-027 SHALL, without WORD_BUF_LEVEL_EN, omit port level; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL check latency: reset, then push 16'hA1B2 with ready_in=0 -> next cycle valid_out=1 and data_out=16'hA1B2, held until ready_in=1, then valid_out=0.
REQ-029 SHALL check fill and overflow: DEPTH=4, ready_in=0, push 16'h0001..16'h0005 on consecutive cycles -> full=1 after the 4th push, overflow=1 after the 5th, then drain yields 0001,0002,0003,0004.
REQ-030 SHALL check push on full: with 4 words stored, apply valid_in=1 with 16'h00FF and ready_in=1 in the same cycle -> overflow stays 0, full stays 1, and 16'h00FF is drained last.
REQ-031 SHALL check wrap-around: stream 10 words with ready_in=1 continuously and DEPTH=4 -> all 10 appear in order, one per cycle after the first, and occupancy never exceeds 1.
REQ-032 SHALL check reset mid-operation: with 3 words stored and overflow=1, assert rst for 1 cycle while valid_in=1 -> all outputs return to reset values and the word offered during reset is not stored.
REQ-033 SHALL check the level port: with WORD_BUF_LEVEL_EN defined, the push/pop sequence from REQ-029 gives level 1,2,3,4,4, then decrements to 0 on drain.
